// File: rtl/usb_tx_ctrl_p.sv
// usb_tx_ctrl_p -- USB packet transmit controller.
//
// Sequences one USB packet onto a byte serializer: SYNC byte, PID byte,
// optional payload bytes pulled from a transmit buffer, optional CRC16
// bytes, then a two bit-period end-of-packet.
//
// Optional feature macro: USB_TX_CRC16_EN
//   defined   -> data packets carry the two CRC16 bytes (crc16 port present,
//                crc_clr pulses while idle)
//   undefined -> no CRC bytes, no crc16 port, crc_clr held at 0
//
// Handshake semantics: tx_start is a single-cycle request sampled only in
// IDLE; byte_done is consumed only in SYNC/PID/SEND_DATA/CRC_LO/CRC_HI,
// bit_done only in EOP1/EOP2. A pulse on either in any other state is
// dropped, and the state holds until the consuming pulse arrives.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tx_start, tx_packet      start request and packet type (0..7)
//   tx_packet_data           head byte of the transmit buffer
//   buffer_occupancy         bytes held in the transmit buffer
//   byte_done, bit_done      serializer byte / bit-period completion
//   crc16                    running payload CRC (macro builds only)
//   data_to_send             byte presented to the serializer
//   timer_en, timer_clr      bit-period timer control
//   load_en, get_tx_packet_data  payload byte load / buffer pop
//   send_eop                 drive end-of-packet
//   tx_transfer_active       packet in progress
//   tx_error                 one-cycle error pulse
//   crc_clr                  clear the external CRC generator
//   dbg_state_o              current FSM state encoding
module usb_tx_ctrl_p #(
  parameter int MAX_PAYLOAD = 64,
  localparam int OCC_W = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [2:0]       tx_packet,
  input  logic [7:0]       tx_packet_data,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic             byte_done,
  input  logic             bit_done,
`ifdef USB_TX_CRC16_EN
  input  logic [15:0]      crc16,
`endif
  output logic [7:0]       data_to_send,
  output logic             timer_en,
  output logic             timer_clr,
  output logic             load_en,
  output logic             send_eop,
  output logic             tx_transfer_active,
  output logic             get_tx_packet_data,
  output logic             tx_error,
  output logic             crc_clr,
  output logic [3:0]       dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SYNC      = 4'd1,
    S_PID       = 4'd2,
    S_LOAD      = 4'd3,
    S_SEND_DATA = 4'd4,
    S_CRC_LO    = 4'd5,
    S_CRC_HI    = 4'd6,
    S_EOP1      = 4'd7,
    S_EOP2      = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_PAYLOAD);

  state_t           state_q, state_d;
  logic [2:0]       pkt_q, pkt_d;
  logic [OCC_W-1:0] len_q, len_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0]      crc_q, crc_d;
`endif

  logic   start_ok;
  logic   pkt_is_data;
  state_t after_payload;

  assign start_ok    = (tx_packet >= 3'd2) && (tx_packet <= 3'd6) &&
                       (buffer_occupancy <= MAX_OCC);
  assign pkt_is_data = (tx_packet == 3'd2) || (tx_packet == 3'd3);
`ifdef USB_TX_CRC16_EN
  assign after_payload = S_CRC_LO;
`else
  assign after_payload = S_EOP1;
`endif

  assign dbg_state_o = state_q;

  function automatic logic [7:0] pid_byte(input logic [2:0] p);
    case (p)
      3'd2:    pid_byte = 8'hC3;
      3'd3:    pid_byte = 8'h4B;
      3'd4:    pid_byte = 8'hD2;
      3'd5:    pid_byte = 8'h5A;
      3'd6:    pid_byte = 8'h1E;
      default: pid_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pkt_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef USB_TX_CRC16_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef USB_TX_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d            = state_q;
    pkt_d              = pkt_q;
    len_d              = len_q;
    cnt_d              = cnt_q;
    data_d             = data_q;
`ifdef USB_TX_CRC16_EN
    crc_d              = crc_q;
`endif
    data_to_send       = 8'h00;
    timer_en           = 1'b0;
    timer_clr          = 1'b0;
    load_en            = 1'b0;
    send_eop           = 1'b0;
    tx_transfer_active = 1'b0;
    get_tx_packet_data = 1'b0;
    tx_error           = 1'b0;
    crc_clr            = 1'b0;

    if (state_q != S_IDLE && state_q != S_ERROR) begin
      timer_en           = 1'b1;
      tx_transfer_active = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        timer_clr    = 1'b1;
        data_to_send = 8'h01;
`ifdef USB_TX_CRC16_EN
        crc_clr      = 1'b1;
`endif
        cnt_d        = '0;
        if (tx_start) begin
          if (start_ok) begin
            state_d = S_SYNC;
            pkt_d   = tx_packet;
            // Length is frozen here; later occupancy only guards underrun.
            len_d   = pkt_is_data ? buffer_occupancy : '0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_SYNC: begin
        data_to_send = 8'h01;
        if (byte_done) state_d = S_PID;
      end
      S_PID: begin
        data_to_send = pid_byte(pkt_q);
        if (byte_done) begin
          if (pkt_q >= 3'd4)     state_d = S_EOP1;
          else if (len_q == '0)  state_d = after_payload;
          else                   state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_to_send = data_q;
        if (buffer_occupancy == '0) begin
          state_d = S_ERROR;
        end else begin
          load_en            = 1'b1;
          get_tx_packet_data = 1'b1;
          data_d             = tx_packet_data;
          cnt_d              = cnt_q + 1'b1;
          state_d            = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        data_to_send = data_q;
        if (byte_done) begin
          if (cnt_q < len_q) state_d = S_LOAD;
          else               state_d = after_payload;
        end
      end
`ifdef USB_TX_CRC16_EN
      S_CRC_LO: begin
        data_to_send = crc_q[7:0];
        if (byte_done) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        data_to_send = crc_q[15:8];
        if (byte_done) state_d = S_EOP1;
      end
`endif
      S_EOP1: begin
        send_eop = 1'b1;
        if (bit_done) state_d = S_EOP2;
      end
      S_EOP2: begin
        send_eop = 1'b1;
        if (bit_done) state_d = S_IDLE;
      end
      S_ERROR: begin
        tx_error = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef USB_TX_CRC16_EN
    // Snapshot the CRC on the edge that enters CRC_LO so both bytes agree.
    if (state_d == S_CRC_LO && state_q != S_CRC_LO) crc_d = crc16;
`endif
  end

endmodule

// File: tb/tb_usb_tx_ctrl_p.sv
// tb_usb_tx_ctrl_p -- directed, table-driven bench for usb_tx_ctrl_p.
// Works with or without USB_TX_CRC16_EN defined.
module tb_usb_tx_ctrl_p;

  localparam int MAXP  = 64;
  localparam int OCC_W = 7;

`ifdef USB_TX_CRC16_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  // flag order: timer_en, timer_clr, load_en, send_eop, active, get, err, crc_clr
  localparam logic [7:0] F_IDLE = {7'b0100000, CRC_ON};
  localparam logic [7:0] F_BUSY = 8'b1000_1000;
  localparam logic [7:0] F_LOAD = 8'b1010_1100;
  localparam logic [7:0] F_EOP  = 8'b1001_1000;
  localparam logic [7:0] F_ERR  = 8'b0000_0010;

  logic             clk;
  logic             rst;
  logic             tx_start;
  logic [2:0]       tx_packet;
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             byte_done;
  logic             bit_done;
`ifdef USB_TX_CRC16_EN
  logic [15:0]      crc16;
`endif
  logic [7:0]       data_to_send;
  logic             timer_en, timer_clr, load_en, send_eop;
  logic             tx_transfer_active, get_tx_packet_data, tx_error, crc_clr;
  logic [3:0]       dbg_state_o;
  logic [7:0]       flags;

  assign flags = {timer_en, timer_clr, load_en, send_eop,
                  tx_transfer_active, get_tx_packet_data, tx_error, crc_clr};

  usb_tx_ctrl_p #(.MAX_PAYLOAD(MAXP)) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .byte_done          (byte_done),
    .bit_done           (bit_done),
`ifdef USB_TX_CRC16_EN
    .crc16              (crc16),
`endif
    .data_to_send       (data_to_send),
    .timer_en           (timer_en),
    .timer_clr          (timer_clr),
    .load_en            (load_en),
    .send_eop           (send_eop),
    .tx_transfer_active (tx_transfer_active),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_error           (tx_error),
    .crc_clr            (crc_clr),
    .dbg_state_o        (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic             start;
    logic [2:0]       pkt;
    logic [OCC_W-1:0] occ;
    logic [7:0]       data;
    logic             bd;
    logic             bitd;
    logic [15:0]      crc;
    logic             chk_dts;
    logic [7:0]       exp_dts;
    logic [7:0]       exp_flags;
  } vec_t;

  vec_t vecs[0:79];
  int   nv;
  int   n_checks;
  int   n_fail;
  int   load_cnt;

  function automatic vec_t mk(input logic s, input logic [2:0] p,
                              input logic [OCC_W-1:0] o, input logic [7:0] d,
                              input logic bd, input logic bt, input logic [15:0] c,
                              input logic chk, input logic [7:0] dts,
                              input logic [7:0] fl);
    vec_t v;
    v.start = s; v.pkt = p; v.occ = o; v.data = d; v.bd = bd; v.bitd = bt;
    v.crc = c; v.chk_dts = chk; v.exp_dts = dts; v.exp_flags = fl;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic check8(input string name, input string what,
                        input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h want %h", name, what, got, want);
    end
  endtask

  // driver: apply one cycle of inputs after the edge, check mid-cycle
  task automatic cyc(input string name, input vec_t v);
    @(posedge clk);
    #1;
    tx_start         = v.start;
    tx_packet        = v.pkt;
    buffer_occupancy = v.occ;
    tx_packet_data   = v.data;
    byte_done        = v.bd;
    bit_done         = v.bitd;
`ifdef USB_TX_CRC16_EN
    crc16            = v.crc;
`endif
    @(negedge clk);
    if (v.chk_dts) check8(name, "data_to_send", data_to_send, v.exp_dts);
    check8(name, "flags", flags, v.exp_flags);
    if (load_en) load_cnt++;
  endtask

  task automatic idle_inputs();
    tx_start = 0; tx_packet = 0; buffer_occupancy = 0; tx_packet_data = 0;
    byte_done = 0; bit_done = 0;
`ifdef USB_TX_CRC16_EN
    crc16 = 0;
`endif
  endtask

  initial begin
    int lc0;
    n_checks = 0; n_fail = 0; load_cnt = 0; nv = 0;
    rst = 1'b1;
    idle_inputs();

    // ACK: 01, D2, EOP paced by bit_done; stray strobes ignored
    add(mk(1, 4, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_BUSY));
    add(mk(0, 0, 0, 0, 0, 1, 0, 1, 8'h01, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'hD2, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    // DATA1, 3 bytes AA BB CC; occupancy changes do not alter length
    add(mk(1, 3, 3, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 3, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    add(mk(0, 0, 3, 0, 1, 0, 0, 1, 8'h4B, F_BUSY));
    add(mk(0, 0, 3, 8'hAA, 0, 0, 0, 0, 8'h00, F_LOAD));
    add(mk(0, 0, 3, 0, 0, 0, 0, 1, 8'hAA, F_BUSY));
    add(mk(0, 0, 10, 0, 1, 0, 0, 1, 8'hAA, F_BUSY));
    add(mk(0, 0, 10, 8'hBB, 0, 0, 0, 0, 8'h00, F_LOAD));
    add(mk(0, 0, 9, 0, 1, 0, 0, 1, 8'hBB, F_BUSY));
    add(mk(0, 0, 8, 8'hCC, 0, 0, 0, 0, 8'h00, F_LOAD));
`ifdef USB_TX_CRC16_EN
    add(mk(0, 0, 0, 0, 1, 0, 16'h1234, 1, 8'hCC, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 16'hFFFF, 1, 8'h34, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 16'hFFFF, 1, 8'h12, F_BUSY));
`else
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'hCC, F_BUSY));
`endif
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    // DATA0, zero length: no loads
    add(mk(1, 2, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 16'hABCD, 1, 8'hC3, F_BUSY));
`ifdef USB_TX_CRC16_EN
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'hCD, F_BUSY));
    add(mk(0, 0, 0, 0, 1, 0, 0, 1, 8'hAB, F_BUSY));
`endif
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    // illegal starts: OUT, IN, reserved, oversize occupancy
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, F_ERR));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(1, 1, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, F_ERR));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(1, 7, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, F_ERR));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(1, 2, 7'(MAXP + 1), 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, F_ERR));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));

    // reset state
    #12;
    check8("reset", "flags", flags, F_IDLE);
    check8("reset", "data_to_send", data_to_send, 8'h01);
    check8("reset", "state", {4'h0, dbg_state_o}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // table
    for (int i = 0; i < nv; i++) cyc($sformatf("vec%0d", i), vecs[i]);
    n_checks++;
    if (load_cnt != 3) begin
      n_fail++;
      $display("FAIL table_load_count: got %0d want 3", load_cnt);
    end

    // underrun: DATA0 length 4, buffer empties before third LOAD
    lc0 = load_cnt;
    cyc("ur_idle", mk(1, 2, 4, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    cyc("ur_sync", mk(0, 0, 4, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    cyc("ur_pid",  mk(0, 0, 4, 0, 1, 0, 0, 1, 8'hC3, F_BUSY));
    cyc("ur_ld1",  mk(0, 0, 4, 8'h11, 0, 0, 0, 0, 8'h00, F_LOAD));
    cyc("ur_sd1",  mk(0, 0, 3, 0, 1, 0, 0, 1, 8'h11, F_BUSY));
    cyc("ur_ld2",  mk(0, 0, 3, 8'h22, 0, 0, 0, 0, 8'h00, F_LOAD));
    cyc("ur_sd2",  mk(0, 0, 0, 0, 1, 0, 0, 1, 8'h22, F_BUSY));
    cyc("ur_ld3",  mk(0, 0, 0, 8'h33, 0, 0, 0, 0, 8'h00, F_BUSY));
    cyc("ur_err",  mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, F_ERR));
    cyc("ur_idle2", mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    n_checks++;
    if (load_cnt - lc0 != 2) begin
      n_fail++;
      $display("FAIL underrun_load_count: got %0d want 2", load_cnt - lc0);
    end

    // asynchronous reset during SEND_DATA, then a clean ACK
    cyc("rs_idle", mk(1, 2, 2, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    cyc("rs_sync", mk(0, 0, 2, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    cyc("rs_pid",  mk(0, 0, 2, 0, 1, 0, 0, 1, 8'hC3, F_BUSY));
    cyc("rs_ld",   mk(0, 0, 2, 8'h5A, 0, 0, 0, 0, 8'h00, F_LOAD));
    cyc("rs_sd",   mk(0, 0, 2, 0, 0, 0, 0, 1, 8'h5A, F_BUSY));
    #2;
    rst = 1'b1;
    #1;
    check8("rst_mid", "flags", flags, F_IDLE);
    check8("rst_mid", "data_to_send", data_to_send, 8'h01);
    check8("rst_mid", "state", {4'h0, dbg_state_o}, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    cyc("ra_idle", mk(1, 4, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));
    cyc("ra_sync", mk(0, 0, 0, 0, 1, 0, 0, 1, 8'h01, F_BUSY));
    cyc("ra_pid",  mk(0, 0, 0, 0, 1, 0, 0, 1, 8'hD2, F_BUSY));
    cyc("ra_eop1", mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    cyc("ra_eop2", mk(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, F_EOP));
    cyc("ra_idle2", mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h01, F_IDLE));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_ctrl_p.md
USB_TX_CTRL_P -- requirements
Module: usb_tx_ctrl_p

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, maximum data payload bytes per packet (1..1023).
REQ-002 SHALL have derived localparam OCC_W = $clog2(MAX_PAYLOAD+1), width of occupancy and length fields.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port tx_start, input, 1, one-cycle request to send a packet.
REQ-006 SHALL have port tx_packet, input, 3, packet type: 0 OUT, 1 IN, 2 DATA0, 3 DATA1, 4 ACK, 5 NAK, 6 STALL, 7 reserved.
REQ-007 SHALL have port tx_packet_data, input, 8, head byte of the transmit buffer.
REQ-008 SHALL have port buffer_occupancy, input, OCC_W, bytes currently held in the transmit buffer.
REQ-009 SHALL have port byte_done, input, 1, serializer finished the current byte.
REQ-010 SHALL have port bit_done, input, 1, bit-period timer expired.
REQ-011 SHALL have port crc16, input, 16, running CRC16 of the payload (present only with USB_TX_CRC16_EN).
REQ-012 SHALL have port data_to_send, output, 8, byte presented to the serializer.
REQ-013 SHALL have ports timer_en, timer_clr, load_en, send_eop, tx_transfer_active, get_tx_packet_data, tx_error, crc_clr, each an output of width 1.

Function
REQ-014 SHALL implement states IDLE, SYNC, PID, LOAD, SEND_DATA, CRC_LO, CRC_HI, EOP1, EOP2, ERROR.
REQ-015 In IDLE: timer_clr=1, data_to_send=8'h01, crc_clr=1, all other outputs 0.
REQ-016 In IDLE, tx_start with type 2..6 and buffer_occupancy<=MAX_PAYLOAD SHALL go to SYNC next cycle, latching type and length (occupancy for DATA0/1, 0 otherwise).
REQ-017 In IDLE, tx_start with type 0, 1, 7 or occupancy>MAX_PAYLOAD SHALL go to ERROR.
REQ-018 ERROR: tx_error=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 In every state except IDLE and ERROR: timer_en=1, tx_transfer_active=1, timer_clr=0.
REQ-020 SYNC: data_to_send=8'h01; byte_done goes to PID.
REQ-021 PID: data_to_send = C3 (DATA0), 4B (DATA1), D2 (ACK), 5A (NAK), 1E (STALL).
REQ-022 PID on byte_done: handshake goes to EOP1; data with length 0 goes to CRC_LO (macro on) or EOP1 (macro off); otherwise goes to LOAD.
REQ-023 LOAD is one cycle: load_en=1, get_tx_packet_data=1, captures tx_packet_data into data_to_send, increments payload counter, then SEND_DATA.
REQ-024 LOAD with buffer_occupancy==0 (underrun) SHALL go to ERROR, with no load_en and no get_tx_packet_data.
REQ-025 SEND_DATA holds the captured byte; byte_done goes to LOAD if counter<length, else CRC_LO (macro on) or EOP1 (macro off).
REQ-026 Length SHALL be the latched value; later occupancy changes SHALL NOT alter packet length.
REQ-027 EOP1/EOP2: send_eop=1; data_to_send don't-care; bit_done advances EOP1 to EOP2, then EOP2 to IDLE.
REQ-028 byte_done/bit_done outside the states that consume them SHALL be ignored; tx_start outside IDLE SHALL be ignored.
REQ-029 Payload counter SHALL be OCC_W bits, cleared in IDLE, never wrapping for legal lengths.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, asynchronously, including mid-packet, with outputs set per REQ-015 and counter/latches cleared.
REQ-031 After rst deasserts, the first tx_start SHALL be accepted on the next rising edge.

Configuration
REQ-032 With macro USB_TX_CRC16_EN defined: CRC_LO sends crc16[7:0] and CRC_HI sends crc16[15:8], latched on CRC_LO entry, each advancing on byte_done; CRC_HI goes to EOP1.
REQ-033 Without USB_TX_CRC16_EN: CRC states, crc16 port and crc_clr logic absent (crc_clr tied 0); payload goes directly to EOP1.

Verification
REQ-034 ACK with tx_start -> 01, D2, two EOP cycles paced by bit_done, IDLE; tx_error stays 0.
REQ-035 DATA1, occupancy 3, bytes AA/BB/CC -> 01, 4B, AA, BB, CC, then CRC bytes (macro on) or EOP; exactly 3 load_en pulses.
REQ-036 DATA0, occupancy 0 -> 01, C3, CRC/EOP; zero load_en pulses.
REQ-037 tx_start type OUT, or occupancy MAX_PAYLOAD+1 -> one-cycle tx_error, IDLE, tx_transfer_active never 1.
REQ-038 DATA0, length 4, occupancy forced 0 before the 3rd LOAD -> ERROR pulse, IDLE; only 2 load_en pulses.
REQ-039 rst during SEND_DATA -> IDLE outputs same cycle; new ACK transfer then completes normally.
